atm_bank_responder: RTL and testbench
=====================================

Name: atm_bank_responder

Overview:
Host-side responder for the ATM controller. It answers PIN-verify, withdraw, balance-enquiry and mini-statement requests from the ATM FSM, and holds one account's balance, PIN retry counter and withdrawal history. It generates the ATM's pin_check, transaction_success and balance_enquiry_success inputs. Host delay is modelled by a fixed response latency.

Parameters:
AMT_W, 16, width of amounts and balance (unsigned)
PIN_VALUE, 16'h1234, correct account PIN
INIT_BALANCE, 5000, balance loaded at reset
MAX_TRIES, 3, consecutive bad PINs before lockout (>=1)
LATENCY, 4, clock edges from request acceptance to response (>=1)
HIST_DEPTH, 4, withdrawal history entries (power of 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
card_in  in  1  card present; a session exists while high
req_valid  in  1  request strobe from ATM
req_ready  out  1  responder can accept a request
req_op  in  2  0 VERIFY_PIN, 1 WITHDRAW, 2 BALANCE, 3 MINI_STMT
req_pin  in  16  PIN for VERIFY_PIN
req_amount  in  AMT_W  amount for WITHDRAW
rsp_valid  out  1  response beat valid (one cycle per beat)
rsp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 NSF, 4 NOT_AUTH, 5 BAD_AMOUNT
rsp_data  out  AMT_W  balance, or history entry for MINI_STMT
rsp_last  out  1  final beat of a response
pin_check  out  1  level: session authenticated
transaction_success  out  1  one-cycle pulse on successful withdraw
balance_enquiry_success  out  1  one-cycle pulse on successful BALANCE or last MINI_STMT beat
card_locked  out  1  sticky lockout flag

Behaviour:
- Reset (reset=0, async): all outputs 0; balance=INIT_BALANCE; history empty; tries=0; auth=0; state IDLE.
- States: IDLE (no card), READY, BUSY (latency countdown), STMT (streaming).
- IDLE->READY when card_in=1. req_ready=1 only in READY. Acceptance = req_valid & req_ready on a rising edge; req_op, req_pin and req_amount are captured then. req_valid while not ready is ignored, with no queueing.
- Accept -> BUSY. rsp_valid asserts exactly LATENCY edges after the acceptance edge, for one cycle. rsp_last=1 on that beat, except for MINI_STMT. The state returns to READY on the next edge, so back-to-back requests are spaced LATENCY+1 cycles.
- All state updates commit on the response edge, never at acceptance.
- card_locked=1: every accepted request responds LOCKED with no other effect.
- VERIFY_PIN match: auth=1, tries=0, OK.
- VERIFY_PIN mismatch: auth=0, tries+1. If tries reaches MAX_TRIES: card_locked=1, status LOCKED; otherwise BAD_PIN. card_locked stays set until reset.
- WITHDRAW/BALANCE/MINI_STMT with auth=0: NOT_AUTH.
- WITHDRAW amount=0: BAD_AMOUNT.
- WITHDRAW amount>balance: NSF, balance unchanged.
- WITHDRAW otherwise: balance-=amount (amount==balance leaves 0, no wrap); amount pushed into the history (oldest overwritten when full); transaction_success pulses with rsp_valid; rsp_data=new balance.
- BALANCE: rsp_data=balance, OK, balance_enquiry_success pulses with rsp_valid.
- MINI_STMT: after the latency, enters STMT and streams N=min(entries,HIST_DEPTH) beats on consecutive cycles, newest first, all OK. rsp_last and balance_enquiry_success are on beat N. If the history is empty: one beat, rsp_data=0, rsp_last=1.
- rsp_data=0 whenever rsp_valid=0.
- card_in falls in any state: next edge -> IDLE, auth=0. A pending BUSY/STMT response is aborted: no further beats, no debit, no pulses. tries and card_locked persist across cards.
- card_in=0 with req_valid=1: not accepted.

Decomposition:
- Shared package atm_pkg: op codes, status codes, state encoding, and a status-width localparam shared with atm_fsm.
- Sub-module atm_txn_history: circular buffer with push and read-by-age index; write pointer and count, count saturating at HIST_DEPTH.

Test Plan:
- card_in=1, VERIFY_PIN 16'h1234 -> rsp_valid 4 edges after accept, OK, pin_check=1.
- Authenticated WITHDRAW 1200 -> OK, rsp_data=3800, transaction_success 1 cycle. Then WITHDRAW 4000 -> NSF, balance stays 3800. WITHDRAW 0 -> BAD_AMOUNT.
- Three bad PINs -> BAD_PIN, BAD_PIN, LOCKED, card_locked=1. A correct PIN after that -> LOCKED. Re-inserting the card does not clear the lock; only reset does.
- Five withdrawals of 100..500, then MINI_STMT -> 4 consecutive beats 500,400,300,200, rsp_last and balance_enquiry_success on beat 4. On a fresh reset, MINI_STMT -> single beat with rsp_data=0.
- WITHDRAW accepted, card_in dropped 2 cycles later -> no rsp_valid. After re-auth, BALANCE returns an unchanged balance.
- Assert reset mid-BUSY -> outputs 0 immediately; balance=5000 and tries=0 after release.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM bank responder slice.
// Defines the request op codes, the response status codes and the
// responder state encoding. STATUS_W is also used by atm_fsm.
package atm_pkg;

    localparam int unsigned STATUS_W = 3;

    typedef enum logic [1:0] {
        OP_VERIFY_PIN = 2'd0,
        OP_WITHDRAW   = 2'd1,
        OP_BALANCE    = 2'd2,
        OP_MINI_STMT  = 2'd3
    } op_e;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK         = 3'd0,
        ST_BAD_PIN    = 3'd1,
        ST_LOCKED     = 3'd2,
        ST_NSF        = 3'd3,
        ST_NOT_AUTH   = 3'd4,
        ST_BAD_AMOUNT = 3'd5
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_BUSY,
        S_STMT
    } state_e;

endpackage

// File: rtl/atm_bank_responder_if.sv
// Request/response bus between the ATM FSM (master) and the bank
// responder (slave).
//   req_valid/req_ready : request handshake
//   req_op/pin/amount   : request payload, captured on acceptance
//   rsp_valid/last      : one response beat per cycle, last marks the end
//   rsp_status/rsp_data : beat payload (data is 0 when rsp_valid is 0)
interface atm_bank_responder_if
    import atm_pkg::*;
#(
    parameter int unsigned AMT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    op_e              req_op;
    logic [15:0]      req_pin;
    logic [AMT_W-1:0] req_amount;
    logic             rsp_valid;
    status_e          rsp_status;
    logic [AMT_W-1:0] rsp_data;
    logic             rsp_last;

    modport master (
        output req_valid, req_op, req_pin, req_amount,
        input  req_ready, rsp_valid, rsp_status, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_op, req_pin, req_amount,
        output req_ready, rsp_valid, rsp_status, rsp_data, rsp_last
    );

endinterface

// File: rtl/atm_txn_history.sv
// Circular withdrawal history.
//   clk, reset : clock, async active-low reset (clears all entries)
//   push       : store push_data as the newest entry (oldest overwritten)
//   rd_age     : 0 = newest entry, 1 = next older, ...
//   rd_data    : entry selected by rd_age (combinational)
//   count      : valid entries, saturating at DEPTH
module atm_txn_history #(
    parameter int unsigned AMT_W = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [AMT_W-1:0] push_data,
    input  logic [IDX_W-1:0] rd_age,
    output logic [AMT_W-1:0] rd_data,
    output logic [CNT_W-1:0] count
);
    logic [AMT_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + IDX_W'(1);
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Newest entry sits just behind the write pointer; pointer wraps
    // naturally because DEPTH is a power of two.
    assign rd_data = mem[wr_ptr - IDX_W'(1) - rd_age];

endmodule

// File: rtl/atm_bank_responder.sv
// Host-side bank responder for the ATM controller. Holds one account
// (balance, PIN retry counter, lockout, withdrawal history) and answers
// VERIFY_PIN / WITHDRAW / BALANCE / MINI_STMT after a fixed latency.
//   clk, reset              : clock, async active-low reset
//   card_in                 : card present; dropping it aborts any request
//   bus (slave)             : request/response bus
//   pin_check               : session authenticated (level)
//   transaction_success     : pulse with a successful withdraw response
//   balance_enquiry_success : pulse with BALANCE / last MINI_STMT beat
//   card_locked             : sticky until reset
module atm_bank_responder
    import atm_pkg::*;
#(
    parameter int unsigned AMT_W        = 16,
    parameter logic [15:0] PIN_VALUE    = 16'h1234,
    parameter int unsigned INIT_BALANCE = 5000,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned LATENCY      = 4,
    parameter int unsigned HIST_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 card_in,
    atm_bank_responder_if.slave  bus,
    output logic                 pin_check,
    output logic                 transaction_success,
    output logic                 balance_enquiry_success,
    output logic                 card_locked
);
    localparam int unsigned LAT_W = $clog2(LATENCY + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned IDX_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1);

    state_e           state;
    logic [LAT_W-1:0] lat_cnt;
    op_e              op_q;
    logic [15:0]      pin_q;
    logic [AMT_W-1:0] amt_q;
    logic [AMT_W-1:0] balance;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_inc;
    logic [IDX_W-1:0] stmt_idx;
    logic [IDX_W-1:0] hist_age;
    logic [AMT_W-1:0] hist_rd;
    logic [CNT_W-1:0] hist_count;
    logic             hist_push;
    logic [AMT_W-1:0] hist_wdata;

    assign bus.req_ready = (state == S_READY) && card_in;
    assign tries_inc     = tries + TRY_W'(1);
    assign hist_age      = (state == S_STMT) ? stmt_idx : '0;

    atm_txn_history #(
        .AMT_W (AMT_W),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .reset     (reset),
        .push      (hist_push),
        .push_data (hist_wdata),
        .rd_age    (hist_age),
        .rd_data   (hist_rd),
        .count     (hist_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= S_IDLE;
            lat_cnt                 <= '0;
            op_q                    <= OP_VERIFY_PIN;
            pin_q                   <= '0;
            amt_q                   <= '0;
            balance                 <= AMT_W'(INIT_BALANCE);
            tries                   <= '0;
            stmt_idx                <= '0;
            hist_push               <= 1'b0;
            hist_wdata              <= '0;
            pin_check               <= 1'b0;
            card_locked             <= 1'b0;
            transaction_success     <= 1'b0;
            balance_enquiry_success <= 1'b0;
            bus.rsp_valid           <= 1'b0;
            bus.rsp_status          <= ST_OK;
            bus.rsp_data            <= '0;
            bus.rsp_last            <= 1'b0;
        end else begin
            bus.rsp_valid           <= 1'b0;
            bus.rsp_status          <= ST_OK;
            bus.rsp_data            <= '0;
            bus.rsp_last            <= 1'b0;
            transaction_success     <= 1'b0;
            balance_enquiry_success <= 1'b0;
            hist_push               <= 1'b0;

            if (!card_in) begin
                state     <= S_IDLE;
                pin_check <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_READY;

                    S_READY: begin
                        if (bus.req_valid) begin
                            op_q    <= bus.req_op;
                            pin_q   <= bus.req_pin;
                            amt_q   <= bus.req_amount;
                            lat_cnt <= LAT_W'(LATENCY - 1);
                            state   <= S_BUSY;
                        end
                    end

                    S_BUSY: begin
                        if (lat_cnt != '0) begin
                            lat_cnt <= lat_cnt - LAT_W'(1);
                        end else begin
                            // Response edge: every state change commits here.
                            state         <= S_READY;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_last  <= 1'b1;
                            if (card_locked) begin
                                bus.rsp_status <= ST_LOCKED;
                            end else begin
                                case (op_q)
                                    OP_VERIFY_PIN: begin
                                        if (pin_q == PIN_VALUE) begin
                                            pin_check <= 1'b1;
                                            tries     <= '0;
                                        end else begin
                                            pin_check <= 1'b0;
                                            tries     <= tries_inc;
                                            if (tries_inc >= TRY_W'(MAX_TRIES)) begin
                                                card_locked    <= 1'b1;
                                                bus.rsp_status <= ST_LOCKED;
                                            end else begin
                                                bus.rsp_status <= ST_BAD_PIN;
                                            end
                                        end
                                    end
                                    OP_WITHDRAW: begin
                                        if (!pin_check) begin
                                            bus.rsp_status <= ST_NOT_AUTH;
                                        end else if (amt_q == '0) begin
                                            bus.rsp_status <= ST_BAD_AMOUNT;
                                        end else if (amt_q > balance) begin
                                            bus.rsp_status <= ST_NSF;
                                        end else begin
                                            balance             <= balance - amt_q;
                                            bus.rsp_data        <= balance - amt_q;
                                            transaction_success <= 1'b1;
                                            // History write lands one edge later; the
                                            // earliest MINI_STMT read is LATENCY+1 away.
                                            hist_push           <= 1'b1;
                                            hist_wdata          <= amt_q;
                                        end
                                    end
                                    OP_BALANCE: begin
                                        if (!pin_check) begin
                                            bus.rsp_status <= ST_NOT_AUTH;
                                        end else begin
                                            bus.rsp_data            <= balance;
                                            balance_enquiry_success <= 1'b1;
                                        end
                                    end
                                    default: begin
                                        if (!pin_check) begin
                                            bus.rsp_status <= ST_NOT_AUTH;
                                        end else if (hist_count == '0) begin
                                            balance_enquiry_success <= 1'b1;
                                        end else begin
                                            // First beat is the newest entry (age 0).
                                            bus.rsp_data <= hist_rd;
                                            if (hist_count > CNT_W'(1)) begin
                                                bus.rsp_last <= 1'b0;
                                                stmt_idx     <= IDX_W'(1);
                                                state        <= S_STMT;
                                            end else begin
                                                balance_enquiry_success <= 1'b1;
                                            end
                                        end
                                    end
                                endcase
                            end
                        end
                    end

                    S_STMT: begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= hist_rd;
                        if (CNT_W'(stmt_idx) + CNT_W'(1) == hist_count) begin
                            bus.rsp_last            <= 1'b1;
                            balance_enquiry_success <= 1'b1;
                            state                   <= S_READY;
                        end else begin
                            stmt_idx <= stmt_idx + IDX_W'(1);
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed bench for atm_bank_responder with hand-computed expectations.
module tb_atm_bank_responder;
    import atm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic card_in;
    logic pin_check;
    logic transaction_success;
    logic balance_enquiry_success;
    logic card_locked;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [2:0]  r_status;
    logic [15:0] r_data;
    logic        r_last;
    logic        r_ts;
    logic        r_bes;
    int          r_lat;

    atm_bank_responder_if #(.AMT_W(16)) bus ();

    atm_bank_responder #(
        .AMT_W        (16),
        .PIN_VALUE    (16'h1234),
        .INIT_BALANCE (5000),
        .MAX_TRIES    (3),
        .LATENCY      (4),
        .HIST_DEPTH   (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .card_in                 (card_in),
        .bus                     (bus),
        .pin_check               (pin_check),
        .transaction_success     (transaction_success),
        .balance_enquiry_success (balance_enquiry_success),
        .card_locked             (card_locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input op_e op, input logic [15:0] pin, input logic [15:0] amt);
        int n = 0;
        while (!bus.req_ready && n < 10) begin
            tick();
            n++;
        end
        check("req_ready", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_pin    = pin;
        bus.req_amount = amt;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic do_req(input op_e op, input logic [15:0] pin, input logic [15:0] amt);
        int n = 0;
        accept(op, pin, amt);
        do begin
            tick();
            n++;
        end while (!bus.rsp_valid && n < 20);
        r_lat    = n;
        r_status = bus.rsp_status;
        r_data   = bus.rsp_data;
        r_last   = bus.rsp_last;
        r_ts     = transaction_success;
        r_bes    = balance_enquiry_success;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_beats [4];
        logic        seen;
        exp_beats = '{16'd500, 16'd400, 16'd300, 16'd200};

        reset          = 1'b0;
        card_in        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_VERIFY_PIN;
        bus.req_pin    = '0;
        bus.req_amount = '0;
        tick();
        tick();
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_pin_check", pin_check, 0);
        check("rst_card_locked", card_locked, 0);
        check("rst_req_ready", bus.req_ready, 0);
        reset   = 1'b1;
        card_in = 1'b1;

        // Correct PIN: response 4 edges after acceptance
        do_req(OP_VERIFY_PIN, 16'h1234, 0);
        check("pin_lat", r_lat, 4);
        check("pin_status", r_status, 0);
        check("pin_last", r_last, 1);
        check("pin_check", pin_check, 1);

        // Empty history statement: single zero beat
        do_req(OP_MINI_STMT, 0, 0);
        check("empty_status", r_status, 0);
        check("empty_data", r_data, 0);
        check("empty_last", r_last, 1);
        tick();
        check("empty_no_more", bus.rsp_valid, 0);

        do_req(OP_WITHDRAW, 0, 1200);
        check("wd_status", r_status, 0);
        check("wd_data", r_data, 3800);
        check("wd_ts", r_ts, 1);
        tick();
        check("wd_ts_pulse", transaction_success, 0);
        check("idle_data_zero", bus.rsp_data, 0);

        do_req(OP_WITHDRAW, 0, 4000);
        check("nsf_status", r_status, 3);
        check("nsf_ts", r_ts, 0);
        do_req(OP_WITHDRAW, 0, 0);
        check("zero_status", r_status, 5);
        do_req(OP_BALANCE, 0, 0);
        check("bal_status", r_status, 0);
        check("bal_data", r_data, 3800);
        check("bal_bes", r_bes, 1);

        // Five withdrawals then a 4-beat statement, newest first
        for (int i = 1; i <= 5; i++) begin
            do_req(OP_WITHDRAW, 0, 16'(100 * i));
        end
        check("wd5_data", r_data, 2300);
        do_req(OP_MINI_STMT, 0, 0);
        check("stmt_b0_data", r_data, exp_beats[0]);
        check("stmt_b0_last", r_last, 0);
        check("stmt_b0_bes", r_bes, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("stmt_valid", bus.rsp_valid, 1);
            check("stmt_data", bus.rsp_data, exp_beats[k]);
            check("stmt_last", bus.rsp_last, (k == 3) ? 1 : 0);
            check("stmt_bes", balance_enquiry_success, (k == 3) ? 1 : 0);
        end
        tick();
        check("stmt_end", bus.rsp_valid, 0);

        // Card pulled mid-request: no response, no debit
        accept(OP_WITHDRAW, 0, 1000);
        tick();
        tick();
        card_in = 1'b0;
        seen    = 1'b0;
        repeat (8) begin
            tick();
            if (bus.rsp_valid || transaction_success) seen = 1'b1;
        end
        check("abort_no_rsp", seen, 0);
        card_in = 1'b1;
        tick();
        check("abort_auth_clr", pin_check, 0);
        do_req(OP_VERIFY_PIN, 16'h1234, 0);
        do_req(OP_BALANCE, 0, 0);
        check("abort_balance", r_data, 2300);

        // Withdraw the whole balance, then one more unit
        do_req(OP_WITHDRAW, 0, 2300);
        check("all_status", r_status, 0);
        check("all_data", r_data, 0);
        do_req(OP_WITHDRAW, 0, 1);
        check("empty_nsf", r_status, 3);

        // Lockout
        do_req(OP_VERIFY_PIN, 16'h0000, 0);
        check("bad1", r_status, 1);
        check("bad1_auth", pin_check, 0);
        do_req(OP_VERIFY_PIN, 16'h0000, 0);
        check("bad2", r_status, 1);
        do_req(OP_VERIFY_PIN, 16'h0000, 0);
        check("bad3", r_status, 2);
        check("locked", card_locked, 1);
        do_req(OP_VERIFY_PIN, 16'h1234, 0);
        check("locked_good_pin", r_status, 2);
        check("locked_auth", pin_check, 0);
        card_in = 1'b0;
        tick();
        tick();
        card_in = 1'b1;
        check("lock_persist", card_locked, 1);
        do_req(OP_VERIFY_PIN, 16'h1234, 0);
        check("reinsert_locked", r_status, 2);

        // Asynchronous reset in the middle of a busy request
        accept(OP_BALANCE, 0, 0);
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        check("areset_locked", card_locked, 0);
        check("areset_valid", bus.rsp_valid, 0);
        check("areset_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_req(OP_VERIFY_PIN, 16'h0000, 0);
        check("post_rst_bad", r_status, 1);
        do_req(OP_VERIFY_PIN, 16'h1234, 0);
        check("post_rst_ok", r_status, 0);
        do_req(OP_BALANCE, 0, 0);
        check("post_rst_balance", r_data, 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
